// File: rtl/uart_word_loader.sv
// Parses SYNC/ADDR/COUNT/DATA/CHK load packets from the UART byte stream and
// writes little-endian words into memory, with checksum and inter-byte timeout.
module uart_word_loader #(
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    WORD_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_done,
  input  logic [BYTE_WIDTH-1:0] data_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code
);

  localparam int BPW = WORD_WIDTH / BYTE_WIDTH;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
  localparam logic [BIW-1:0] BYTE_LAST  = BIW'(BPW - 1);
  localparam logic [BIW-1:0] BIDX_ONE   = BIW'(1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_CHECK
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_wordIdx;
  logic [BIW-1:0]        r_byteIdx;
  logic [WORD_WIDTH-1:0] r_word;
  logic [BYTE_WIDTH-1:0] r_chk;
  logic [TW-1:0]         r_timer;

  logic                  r_memWe;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [WORD_WIDTH-1:0] r_memWdata;
  logic                  r_busy;
  logic                  r_loadDone;
  logic                  r_loadError;
  logic [1:0]            r_errCode;

  logic [ADDR_WIDTH-1:0] w_byteAsAddr;
  logic [CW-1:0]         w_countLoad;
  logic [WORD_WIDTH-1:0] w_assembled;
  logic                  w_lastByte;
  logic                  w_lastWord;
  logic                  w_timerHit;
  logic                  w_write;
  logic                  w_done;
  logic                  w_bad;
  logic                  w_timeout;

  // A COUNT byte of zero stands for a full 2^ADDR_WIDTH-word load.
  assign w_byteAsAddr = ADDR_WIDTH'(data_in);
  assign w_countLoad  = (w_byteAsAddr == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                             : {1'b0, w_byteAsAddr};
  assign w_lastByte   = (r_byteIdx == BYTE_LAST);
  assign w_lastWord   = (r_wordIdx == (r_count - CNT_ONE));
  assign w_timerHit   = (r_timer == TIMER_LAST) && !rx_done;

  always_comb begin
    w_assembled = r_word;
    for (int b = 0; b < BPW; b++) begin
      if (r_byteIdx == BIW'(b)) begin
        w_assembled[b*BYTE_WIDTH +: BYTE_WIDTH] = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_write     = 1'b0;
    w_done      = 1'b0;
    w_bad       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_done && (data_in == SYNC_BYTE)) begin
          w_nextState = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_done) begin
          w_nextState = S_COUNT;
        end else if (w_timerHit) begin
          w_nextState = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_COUNT: begin
        if (rx_done) begin
          w_nextState = S_DATA;
        end else if (w_timerHit) begin
          w_nextState = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_DATA: begin
        // SYNC_BYTE values are ordinary payload here; no resync mid-packet.
        if (rx_done) begin
          if (w_lastByte) begin
            w_write = 1'b1;
            if (w_lastWord) begin
              w_nextState = S_CHECK;
            end
          end
        end else if (w_timerHit) begin
          w_nextState = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_CHECK: begin
        if (rx_done) begin
          w_nextState = S_IDLE;
          if (data_in == r_chk) begin
            w_done = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end else if (w_timerHit) begin
          w_nextState = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_wordIdx   <= '0;
      r_byteIdx   <= '0;
      r_word      <= '0;
      r_chk       <= '0;
      r_timer     <= '0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_busy      <= 1'b0;
      r_loadDone  <= 1'b0;
      r_loadError <= 1'b0;
      r_errCode   <= 2'b00;
    end else begin
      r_memWe     <= w_write;
      r_loadDone  <= w_done;
      r_loadError <= w_bad | w_timeout;
      // busy stays up through the cycle that carries the completion pulse.
      r_busy      <= (w_nextState != S_IDLE) | w_done | w_bad | w_timeout;

      if (rx_done || (w_nextState == S_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TIMER_ONE;
      end

      if (w_write) begin
        r_memAddr  <= r_base + r_wordIdx[ADDR_WIDTH-1:0];
        r_memWdata <= w_assembled;
        r_wordIdx  <= r_wordIdx + CNT_ONE;
      end

      if (rx_done) begin
        case (r_state)
          S_IDLE: begin
            if (data_in == SYNC_BYTE) begin
              r_errCode <= 2'b00;
            end
          end
          S_ADDR: begin
            r_base <= w_byteAsAddr;
            r_chk  <= data_in;
          end
          S_COUNT: begin
            r_count   <= w_countLoad;
            r_chk     <= r_chk ^ data_in;
            r_byteIdx <= '0;
            r_wordIdx <= '0;
          end
          S_DATA: begin
            r_word    <= w_assembled;
            r_chk     <= r_chk ^ data_in;
            r_byteIdx <= w_lastByte ? '0 : (r_byteIdx + BIDX_ONE);
          end
          default: begin
          end
        endcase
      end

      if (w_bad) begin
        r_errCode <= 2'b01;
      end else if (w_timeout) begin
        r_errCode <= 2'b10;
      end
    end
  end

  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign busy       = r_busy;
  assign load_done  = r_loadDone;
  assign load_error = r_loadError;
  assign err_code   = r_errCode;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed self-checking bench for uart_word_loader: single word, garbage before
// sync, address wrap, bad checksum, timeout, reset mid-word, fast vs slow bytes.
module tb_uart_word_loader;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic [7:0]  data_in;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int nVectors    = 0;
  int nMiscompare = 0;

  logic [7:0]  wrAddr[$];
  logic [31:0] wrData[$];
  int          doneCnt = 0;
  int          errCnt  = 0;
  int          bothCnt = 0;

  uart_word_loader #(
    .BYTE_WIDTH    (8),
    .WORD_WIDTH    (32),
    .ADDR_WIDTH    (8),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .data_in   (data_in),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Record every write and completion pulse seen during the previous cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
    if (load_done) doneCnt++;
    if (load_error) errCnt++;
    if (load_done && load_error) bothCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompare++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge and
  // the task returns at the following falling edge with rx_done low again.
  task automatic applyStimulus(input logic [7:0] b);
    rx_done = 1'b1;
    data_in = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic runSingleWord(input string tag, input int gap, input logic [7:0] chk);
    logic [7:0] hdr[6];
    int doneBefore, errBefore, wrBefore;
    logic good;
    hdr = '{8'hA5, 8'h10, 8'h01, 8'hEF, 8'hBE, 8'hAD};
    good       = (chk == 8'h33);
    doneBefore = doneCnt;
    errBefore  = errCnt;
    wrBefore   = wrAddr.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(hdr[i]);
      idle(gap);
    end
    checkOutput({tag, "_busyMid"}, 32'(busy), 32'd1);
    applyStimulus(8'hDE);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'h10);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'hDEADBEEF);
    idle(gap);
    applyStimulus(chk);
    checkOutput({tag, "_weAfterChk"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_done"}, 32'(load_done), 32'(good));
    checkOutput({tag, "_error"}, 32'(load_error), 32'(!good));
    checkOutput({tag, "_busyPulse"}, 32'(busy), 32'd1);
    checkOutput({tag, "_errCode"}, 32'(err_code), good ? 32'd0 : 32'd1);
    idle(2);
    checkOutput({tag, "_busyEnd"}, 32'(busy), 32'd0);
    checkOutput({tag, "_donePulses"}, 32'(doneCnt - doneBefore), 32'(good));
    checkOutput({tag, "_errPulses"}, 32'(errCnt - errBefore), 32'(!good));
    checkOutput({tag, "_writes"}, 32'(wrAddr.size() - wrBefore), 32'd1);
    checkOutput({tag, "_addrHold"}, 32'(mem_addr), 32'h10);
    checkOutput({tag, "_dataHold"}, mem_wdata, 32'hDEADBEEF);
  endtask

  initial begin
    logic [7:0]  garbage[3];
    logic [7:0]  wrapAddr[3];
    logic [31:0] wrapData[3];
    int          wrBefore;
    int          doneBefore;

    rst     = 1'b1;
    rx_done = 1'b0;
    data_in = 8'h00;
    idle(3);

    // Reset state.
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_error", 32'(load_error), 32'd0);
    checkOutput("rst_errCode", 32'(err_code), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single word with back-to-back bytes.
    runSingleWord("b2b", 0, 8'h33);

    // Garbage before sync, then the same packet with slowly spaced bytes.
    garbage = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(garbage[i]);
      checkOutput("garbage_busy", 32'(busy), 32'd0);
      idle(3);
    end
    runSingleWord("slow", 3, 8'h33);

    // Address wrap: three words starting at 0xFE, payload bytes 01..0C.
    wrapAddr = '{8'hFE, 8'hFF, 8'h00};
    wrapData = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    wrBefore   = wrAddr.size();
    doneBefore = doneCnt;
    applyStimulus(8'hA5);
    applyStimulus(8'hFE);
    applyStimulus(8'h03);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(8'(i));
      idle(2);
    end
    applyStimulus(8'hF1);
    checkOutput("wrap_done", 32'(load_done), 32'd1);
    idle(2);
    checkOutput("wrap_writes", 32'(wrAddr.size() - wrBefore), 32'd3);
    checkOutput("wrap_donePulses", 32'(doneCnt - doneBefore), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (wrBefore + i < wrAddr.size()) begin
        checkOutput("wrap_addr", 32'(wrAddr[wrBefore+i]), 32'(wrapAddr[i]));
        checkOutput("wrap_data", wrData[wrBefore+i], wrapData[i]);
      end
    end

    // Bad checksum: write still lands, error is sticky.
    runSingleWord("badchk", 0, 8'h34);
    idle(5);
    checkOutput("badchk_sticky", 32'(err_code), 32'd1);

    // Timeout after ADDR byte; SYNC clears the sticky checksum error first.
    applyStimulus(8'hA5);
    checkOutput("to_syncClears", 32'(err_code), 32'd0);
    applyStimulus(8'h10);
    idle(TIMEOUT - 1);
    checkOutput("to_notYet", 32'(load_error), 32'd0);
    checkOutput("to_busyBefore", 32'(busy), 32'd1);
    idle(1);
    checkOutput("to_error", 32'(load_error), 32'd1);
    checkOutput("to_errCode", 32'(err_code), 32'd2);
    checkOutput("to_done", 32'(load_done), 32'd0);
    idle(1);
    checkOutput("to_busyAfter", 32'(busy), 32'd0);
    checkOutput("to_errorOnce", 32'(load_error), 32'd0);
    checkOutput("to_errCodeHold", 32'(err_code), 32'd2);

    runSingleWord("afterTo", 0, 8'h33);

    // Reset mid-word after 2 of 4 data bytes.
    wrBefore = wrAddr.size();
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("midRst_we", 32'(mem_we), 32'd0);
    checkOutput("midRst_addr", 32'(mem_addr), 32'd0);
    checkOutput("midRst_wdata", mem_wdata, 32'd0);
    checkOutput("midRst_busy", 32'(busy), 32'd0);
    checkOutput("midRst_done", 32'(load_done), 32'd0);
    checkOutput("midRst_error", 32'(load_error), 32'd0);
    checkOutput("midRst_errCode", 32'(err_code), 32'd0);
    idle(2);
    checkOutput("midRst_noWrite", 32'(wrAddr.size() - wrBefore), 32'd0);

    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    applyStimulus(8'h01);
    applyStimulus(8'h44);
    applyStimulus(8'h33);
    applyStimulus(8'h22);
    applyStimulus(8'h11);
    checkOutput("fresh_we", 32'(mem_we), 32'd1);
    checkOutput("fresh_addr", 32'(mem_addr), 32'h20);
    checkOutput("fresh_wdata", mem_wdata, 32'h11223344);
    applyStimulus(8'h65);
    checkOutput("fresh_done", 32'(load_done), 32'd1);
    checkOutput("fresh_errCode", 32'(err_code), 32'd0);
    idle(2);

    checkOutput("neverBoth", 32'(bothCnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompare);
    $finish;
  end

endmodule
